fft_frame_ctrl: RTL and testbench
=================================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter: FRAME_BITS, 1024, SPI bits per valid frame.
REQ-002 Parameter: TIMEOUT_CYCLES, 4096, max clk cycles allowed in RUN.
REQ-003 clk  in  1  system clock; all state updates on posedge clk.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 spi_cs  in  1  MCU chip select, asynchronous; high = transfer active.
REQ-006 spi_sck  in  1  MCU serial clock, asynchronous; spi_sck <= clk/4.
REQ-007 fft_done  in  1  FFT engine done level.
REQ-008 buf_ready  in  1  output collector signals all 32 result words captured.
REQ-009 fft_load  out  1  one-cycle pulse; FFT samples its 1024-bit input frame.
REQ-010 mcu_irq  out  1  level; results ready for MCU readback.
REQ-011 frame_err  out  1  one-cycle pulse; frame rejected (bit count or timeout).
REQ-012 overrun  out  1  sticky; transfer started while FFT busy; cleared only by reset.
REQ-013 state  out  3  current FSM state encoding, for debug.
REQ-014 frame_cnt  out  16  count of frames reaching READY; wraps 65535 -> 0.

Function
REQ-015 spi_cs, spi_sck SHALL pass 2-flop synchronizers plus one delay flop; cs_rise, cs_fall, sck_rise are single-cycle pulses from synchronized values.
REQ-016 States: IDLE, RECV, LOAD, RUN, COLLECT, READY.
REQ-017 IDLE: cs_rise -> RECV, bit counter cleared to 0.
REQ-018 RECV: each sck_rise increments 11-bit bit counter, saturating at 2047.
REQ-019 RECV, cs_fall, count == FRAME_BITS -> LOAD; count != FRAME_BITS -> IDLE, frame_err pulses.
REQ-020 LOAD: fft_load = 1 for exactly one cycle; unconditional -> RUN; timeout counter cleared.
REQ-021 fft_load SHALL rise at the 4th posedge after the first posedge sampling spi_cs low (2 sync + edge + state).
REQ-022 RUN: fft_done = 1 -> COLLECT; counter reaching TIMEOUT_CYCLES-1 without fft_done -> IDLE, frame_err pulses.
REQ-023 RUN: fft_done and timeout in the same cycle -> COLLECT (done wins).
REQ-024 COLLECT: buf_ready = 1 -> READY; no timeout.
REQ-025 READY: mcu_irq = 1; frame_cnt increments once on entry.
REQ-026 READY: cs_rise -> RECV, mcu_irq drops same cycle, bit counter cleared (readback overlaps next frame input).
REQ-027 cs_rise in LOAD, RUN or COLLECT: overrun set, state unchanged, SPI bits ignored.
REQ-028 cs_fall outside RECV ignored; sck_rise outside RECV ignored.
REQ-029 fft_load, frame_err, mcu_irq SHALL be registered Moore outputs, glitch-free.

Reset
REQ-030 reset = 1 at posedge: state IDLE, fft_load 0, mcu_irq 0, frame_err 0, overrun 0, frame_cnt 0, counters 0, synchronizer flops 0.
REQ-031 reset mid-operation (any state) SHALL abort the frame without frame_err pulse; spi_cs high at reset release does not produce cs_rise until it falls and rises again.

Structure
REQ-032 Package fft_ctrl_pkg: state enum (3-bit), FRAME_BITS, TIMEOUT_CYCLES defaults, bit-counter width.
REQ-033 Sub-module sync_edge (2-flop sync + rise/fall pulse outputs), instantiated for spi_cs and spi_sck.
REQ-034 Single FSM always_ff with separate next-state logic; no latches; no clocks derived from spi_sck.

Verification
REQ-035 Reset, then 1024 sck pulses within cs, fft_done after 100 cycles, buf_ready after 64 more -> one fft_load pulse, mcu_irq = 1, frame_cnt = 1.
REQ-036 1023 sck pulses then cs low -> frame_err one pulse, state IDLE, no fft_load.
REQ-037 Valid frame, fft_done never asserted -> frame_err at RUN cycle 4095, state IDLE, mcu_irq 0.
REQ-038 cs raised during RUN -> overrun = 1 and stays 1; FSM completes current frame to READY normally.
REQ-039 In READY, second valid frame -> mcu_irq falls on cs_rise, second fft_load, frame_cnt = 2.
REQ-040 reset asserted mid-RECV with cs held high -> IDLE; no cs_rise, no frame_err until cs toggles.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared types and defaults for the FFT frame controller.
// Holds the FSM state enum, frame/timeout defaults and counter widths.
package fft_ctrl_pkg;

    localparam int FRAME_BITS_DEF     = 1024;
    localparam int TIMEOUT_CYCLES_DEF = 4096;
    localparam int BIT_CNT_W          = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECV    = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RUN     = 3'd3,
        ST_COLLECT = 3'd4,
        ST_READY   = 3'd5
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus delay flop with registered edge pulses.
// Ports: clk, reset (sync, active-high), d_i async in, rise_o/fall_o pulses.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic       s1_q, s2_q, s3_q;
    logic [1:0] fill_q;
    logic       armed_q;
    logic       rise_q, fall_q;

    // A rise only counts once a settled low has been seen after reset,
    // so a line already high at reset release is not taken as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            if (fill_q != 2'd3)
                fill_q <= fill_q + 2'd1;
            if (fill_q == 2'd3 && !s3_q)
                armed_q <= 1'b1;
            rise_q <= armed_q & s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame controller between an SPI-fed MCU, an FFT engine and a collector.
// Ports: clk, reset, spi_cs, spi_sck, fft_done, buf_ready -> fft_load,
// mcu_irq, frame_err, overrun, state, frame_cnt.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int FRAME_BITS     = FRAME_BITS_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_cs,
    input  logic        spi_sck,
    input  logic        fft_done,
    input  logic        buf_ready,
    output logic        fft_load,
    output logic        mcu_irq,
    output logic        frame_err,
    output logic        overrun,
    output logic [2:0]  state,
    output logic [15:0] frame_cnt
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BIT_CNT_W-1:0] BITS_OK = BIT_CNT_W'(FRAME_BITS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic cs_rise, cs_fall, sck_rise, sck_fall_unused;

    state_e               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 err_d;
    logic                 ovr_q, ovr_d;
    logic                 load_q, irq_q, err_q;
    logic [15:0]          cnt_q;

    sync_edge u_cs (
        .clk    (clk),
        .reset  (reset),
        .d_i    (spi_cs),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    sync_edge u_sck (
        .clk    (clk),
        .reset  (reset),
        .d_i    (spi_sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall_unused)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        err_d     = 1'b0;
        ovr_d     = ovr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_rise) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = '0;
                end
            end
            ST_RECV: begin
                if (cs_fall) begin
                    if (bit_cnt_q == BITS_OK) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end else if (sck_rise && bit_cnt_q != '1) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_LOAD: begin
                if (cs_rise)
                    ovr_d = 1'b1;
                state_d = ST_RUN;
                tmo_d   = '0;
            end
            ST_RUN: begin
                if (cs_rise)
                    ovr_d = 1'b1;
                // Done takes priority over a timeout landing on the same cycle.
                if (fft_done) begin
                    state_d = ST_COLLECT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_COLLECT: begin
                if (cs_rise)
                    ovr_d = 1'b1;
                if (buf_ready)
                    state_d = ST_READY;
            end
            ST_READY: begin
                // Next frame may arrive while MCU is still reading back.
                if (cs_rise) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs registered from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
            ovr_q     <= 1'b0;
            load_q    <= 1'b0;
            irq_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_q     <= tmo_d;
            ovr_q     <= ovr_d;
            load_q    <= (state_d == ST_LOAD);
            irq_q     <= (state_d == ST_READY);
            err_q     <= err_d;
            if (state_d == ST_READY && state_q != ST_READY)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign fft_load  = load_q;
    assign mcu_irq   = irq_q;
    assign frame_err = err_q;
    assign overrun   = ovr_q;
    assign state     = state_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with hand-computed expectations.
// Covers valid frames, short frame, timeout, overrun and reset mid-frame.
module tb_fft_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_cs = 1'b0;
    logic        spi_sck = 1'b0;
    logic        fft_done = 1'b0;
    logic        buf_ready = 1'b0;
    logic        fft_load, mcu_irq, frame_err, overrun;
    logic [2:0]  state;
    logic [15:0] frame_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int load_cnt = 0;
    int err_cnt = 0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RECV = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_COLL = 3'd4;
    localparam logic [2:0] S_RDY  = 3'd5;

    fft_frame_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .spi_cs    (spi_cs),
        .spi_sck   (spi_sck),
        .fft_done  (fft_done),
        .buf_ready (buf_ready),
        .fft_load  (fft_load),
        .mcu_irq   (mcu_irq),
        .frame_err (frame_err),
        .overrun   (overrun),
        .state     (state),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fft_load)  load_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sck_bits(input int n);
        for (int i = 0; i < n; i++) begin
            spi_sck = 1'b1;
            tick(); tick();
            spi_sck = 1'b0;
            tick(); tick();
        end
        tick(); tick();
    endtask

    task automatic send_frame(input int n);
        spi_cs = 1'b1;
        repeat (5) tick();
        sck_bits(n);
        spi_cs = 1'b0;
        repeat (5) tick();
    endtask

    task automatic finish_frame();
        repeat (10) tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        repeat (3) tick();
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        tick();
    endtask

    int n;

    initial begin
        repeat (3) tick();
        chk("rst_state", state, S_IDLE);
        chk("rst_load", fft_load, 0);
        chk("rst_irq", mcu_irq, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_cnt", frame_cnt, 0);
        reset = 1'b0;
        repeat (6) tick();

        // Valid frame with load latency checks
        spi_cs = 1'b1;
        repeat (5) tick();
        chk("f1_recv", state, S_RECV);
        sck_bits(1024);
        spi_cs = 1'b0;
        tick();
        tick();
        chk("lat_p1", fft_load, 0);
        tick();
        chk("lat_p2", fft_load, 0);
        tick();
        chk("lat_p3", fft_load, 1);
        chk("lat_p3_st", state, S_LOAD);
        tick();
        chk("lat_p4", fft_load, 0);
        chk("f1_run", state, S_RUN);
        repeat (100) tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        chk("f1_coll", state, S_COLL);
        repeat (64) tick();
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        chk("f1_rdy", state, S_RDY);
        chk("f1_irq", mcu_irq, 1);
        chk("f1_cnt", frame_cnt, 1);
        chk("f1_loads", load_cnt, 1);
        chk("f1_errs", err_cnt, 0);

        // Second frame overlapping readback
        spi_cs = 1'b1;
        repeat (3) tick();
        chk("f2_irq_hold", mcu_irq, 1);
        tick();
        chk("f2_irq_drop", mcu_irq, 0);
        chk("f2_recv", state, S_RECV);
        sck_bits(1024);
        spi_cs = 1'b0;
        repeat (5) tick();
        chk("f2_loads", load_cnt, 2);
        finish_frame();
        chk("f2_rdy", state, S_RDY);
        chk("f2_irq", mcu_irq, 1);
        chk("f2_cnt", frame_cnt, 2);

        // Short frame of 1023 bits
        spi_cs = 1'b1;
        repeat (5) tick();
        sck_bits(1023);
        spi_cs = 1'b0;
        repeat (4) tick();
        chk("short_err", frame_err, 1);
        chk("short_st", state, S_IDLE);
        tick();
        chk("short_pulse", frame_err, 0);
        chk("short_errs", err_cnt, 1);
        chk("short_loads", load_cnt, 2);

        // Overrun during RUN
        send_frame(1024);
        chk("ovr_run", state, S_RUN);
        spi_cs = 1'b1;
        repeat (6) tick();
        chk("ovr_set", overrun, 1);
        chk("ovr_st", state, S_RUN);
        spi_cs = 1'b0;
        repeat (6) tick();
        chk("ovr_st2", state, S_RUN);
        finish_frame();
        chk("ovr_rdy", state, S_RDY);
        chk("ovr_cnt", frame_cnt, 3);
        chk("ovr_keep", overrun, 1);

        // Timeout in RUN
        spi_cs = 1'b1;
        repeat (5) tick();
        sck_bits(1024);
        spi_cs = 1'b0;
        n = 0;
        while (state !== S_RUN && n < 20) begin
            tick();
            n++;
        end
        chk("tmo_enter", state, S_RUN);
        n = 0;
        while (frame_err !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 4096);
        chk("tmo_st", state, S_IDLE);
        chk("tmo_irq", mcu_irq, 0);
        chk("tmo_cnt", frame_cnt, 3);

        // Reset mid-RECV with cs held high
        spi_cs = 1'b1;
        repeat (5) tick();
        sck_bits(10);
        chk("mid_recv", state, S_RECV);
        n = err_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_idle", state, S_IDLE);
        chk("mid_ovr", overrun, 0);
        chk("mid_cnt", frame_cnt, 0);
        repeat (20) tick();
        chk("mid_stay", state, S_IDLE);
        chk("mid_noerr", err_cnt, n);
        spi_cs = 1'b0;
        repeat (6) tick();
        chk("mid_low", state, S_IDLE);
        spi_cs = 1'b1;
        repeat (4) tick();
        chk("mid_rearm", state, S_RECV);
        spi_cs = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
